data_mem_access_ctrl: RTL and testbench
=======================================

Name: data_mem_access_ctrl

Overview:
- Sequencing controller and arbiter in front of data_memory.
- Shares the single data_memory port between two requesters: port 0 (CPU load/store unit) and port 1 (loader/debug DMA).
- Adds sub-word support. Byte and halfword stores are done as word read-modify-write. Byte and halfword loads are done as a word read followed by lane extraction.
- data_memory itself only ever sees aligned word accesses (size 2'b11).

Parameters:
- FIXED_PRIORITY, 0, 1 = port 0 always wins; 0 = round-robin between ports.
- BIG_ENDIAN, 1, 1 = byte offset 0 maps to bits [31:24] (MIPS); 0 = byte offset 0 maps to bits [7:0].

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- p0_req_in  in  1  port 0 request; held until p0_ack_out is sampled high
- p0_we_in  in  1  1 = store, 0 = load
- p0_size_in  in  2  2'b00 byte, 2'b01 half, 2'b11 word; 2'b10 treated as word
- p0_addr_in  in  32  byte address
- p0_wdata_in  in  32  store data, right-aligned
- p0_rdata_out  out  32  load data, right-aligned, zero-extended
- p0_ack_out  out  1  one-cycle completion pulse
- p0_err_out  out  1  misalignment flag, valid with ack
- p1_*  same set as p0_* for port 1
- mem_addr_out  out  32  {addr[31:2],2'b00}
- mem_wdata_out  out  32  word to write
- mem_re_out  out  1  read enable
- mem_we_out  out  1  write enable
- mem_size_out  out  2  constant 2'b11
- mem_rdata_in  in  32  combinational read data from data_memory

Behaviour:
- Reset:
  - State goes to IDLE.
  - All outputs are 0 except mem_size_out = 2'b11.
  - last_grant = 1, so port 0 wins first.
  - Reset asserted mid-operation abandons the transaction. mem_we_out drops immediately, so no partial write occurs. No ack is issued.
- States: IDLE, RD, WR, RMW_RD, RMW_WR, ACK.
- IDLE:
  - Arbitrate on the sampled req signals.
  - In round-robin mode the port not granted last time wins a tie.
  - Latch the winner's id, we, size, addr and wdata.
  - Alignment check: half requires addr[0] = 0; word requires addr[1:0] = 0.
  - Misaligned request: go to ACK with err = 1 and rdata = 0. No memory access is made.
  - Otherwise the next state is:
    - RD for loads of any size;
    - WR for word stores;
    - RMW_RD for byte and half stores.
- RD:
  - mem_re_out = 1.
  - Capture the lane-extracted mem_rdata_in at the edge.
  - Next state: ACK.
- WR:
  - mem_we_out = 1 and mem_wdata_out = latched wdata.
  - Next state: ACK.
- RMW_RD:
  - mem_re_out = 1.
  - Capture the merged word (old word with the target lane replaced by wdata[7:0] or wdata[15:0]).
  - Next state: RMW_WR.
- RMW_WR:
  - mem_we_out = 1 with the merged word.
  - Next state: ACK.
- ACK:
  - Granted port's ack_out = 1 for exactly one cycle, with rdata_out and err_out valid.
  - Req is not sampled in this state.
  - Next state: IDLE.
  - A requester still holding req on the following edge is treated as issuing a new request.
- Lane selection:
  - Byte lane index is addr[1:0]; half lane index is addr[1].
  - The BIG_ENDIAN mapping applies to both merge and extract.
- Latency from the req-sampled edge to the ack cycle:
  - load or word store: 2 cycles;
  - sub-word store: 3 cycles;
  - misaligned request: 1 cycle.
- The non-granted port waits with ack = 0. Its request is not lost.
- rdata_out and err_out hold their values until that port's next ack. The ungranted port's outputs are unchanged.
- mem_re_out and mem_we_out are never both high. Neither is high outside RD/WR/RMW states.
- Address wrap and segment decode are left to data_memory. The controller passes addr[31:2] unchanged.

Decomposition:
- Package mem_ctrl_pkg:
  - size encodings SIZE_BYTE, SIZE_HALF, SIZE_WORD;
  - state enum;
  - port-id constants.
- One combinational sub-module, mem_lane_unit:
  - inputs: word, addr[1:0], size, wdata, BIG_ENDIAN;
  - outputs: extracted load data and merged store word.

Test Plan:
- Word store, port 0, addr 0x10000010, data 0xDEADBEEF → one mem_we cycle, mem_addr 0x10000010, ack 2 cycles after sample. A following word load returns 0xDEADBEEF.
- Word at 0x10000010 = 0x11223344, byte store 0xA5 to 0x10000011 → mem_re cycle, then mem_we with 0x11A53344, ack 3 cycles after sample.
- Half load from 0x10000012 of 0x11A53344 → rdata 0x00003344, err 0. A byte load from 0x10000010 returns 0x00000011.
- Both ports requesting continuously, FIXED_PRIORITY = 0 → acks alternate 0,1,0,1. With FIXED_PRIORITY = 1, only port 0 is acked until p0_req drops, then port 1 is served.
- Half store to 0x10000013 → ack next cycle with err = 1, rdata 0, no mem_re or mem_we. The memory word is unchanged.
- Reset asserted during RMW_RD → all outputs 0 immediately, no mem_we pulse, memory word unchanged, state IDLE after release. A re-issued request completes normally.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Purpose: shared encodings for the data_memory access controller (sizes, FSM states, port ids).
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package mem_ctrl_pkg;

   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b11;

   localparam logic PORT_0 = 1'b0;
   localparam logic PORT_1 = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD,
      ST_WR,
      ST_RMW_RD,
      ST_RMW_WR,
      ST_ACK
   } state_t;

   // One latched request; size 2'b10 is carried as-is and treated as a word downstream.
   typedef struct packed {
      logic        we;
      logic [1:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
   } req_t;

   // Byte accesses are never misaligned; half needs addr[0]=0; word (and 2'b10) needs addr[1:0]=0.
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
      case (size)
         SIZE_BYTE: is_misaligned = 1'b0;
         SIZE_HALF: is_misaligned = offset[0];
         default:   is_misaligned = |offset;
      endcase
   endfunction

   function automatic logic is_subword(input logic [1:0] size);
      is_subword = (size == SIZE_BYTE) || (size == SIZE_HALF);
   endfunction

endpackage

// File: rtl/mem_lane_unit.sv
// Purpose: sub-word lane extract (loads) and lane merge (stores) on a 32-bit memory word.
// Latency: purely combinational.
// Backpressure: none; outputs follow inputs.
// Ports: word = old memory word, addr_lo = byte offset, size = access size, wdata = right-aligned
//        store data; load_data = right-aligned zero-extended lane, merged_word = word with lane replaced.
module mem_lane_unit
   import mem_ctrl_pkg::*;
#(
   parameter bit BIG_ENDIAN = 1'b1
) (
   input  logic [31:0] word,
   input  logic [1:0]  addr_lo,
   input  logic [1:0]  size,
   input  logic [31:0] wdata,
   output logic [31:0] load_data,
   output logic [31:0] merged_word
);

   logic [1:0] byte_lane;
   logic       half_lane;
   logic [4:0] byte_shift;
   logic [4:0] half_shift;

   always_comb begin
      // Lane numbers count from bit 0; big-endian puts offset 0 in the top lane.
      byte_lane  = BIG_ENDIAN ? ~addr_lo : addr_lo;
      half_lane  = BIG_ENDIAN ? ~addr_lo[1] : addr_lo[1];
      byte_shift = {byte_lane, 3'b000};
      half_shift = {half_lane, 4'b0000};

      case (size)
         SIZE_BYTE: begin
            load_data   = (word >> byte_shift) & 32'h0000_00FF;
            merged_word = (word & ~(32'h0000_00FF << byte_shift))
                        | ({24'h0, wdata[7:0]} << byte_shift);
         end
         SIZE_HALF: begin
            load_data   = (word >> half_shift) & 32'h0000_FFFF;
            merged_word = (word & ~(32'h0000_FFFF << half_shift))
                        | ({16'h0, wdata[15:0]} << half_shift);
         end
         default: begin
            load_data   = word;
            merged_word = wdata;
         end
      endcase
   end

endmodule

// File: rtl/data_mem_access_ctrl.sv
// Purpose: arbitrates two requesters onto one word-only data_memory port; byte/half via RMW or extract.
// Latency: req-sample edge to ack cycle = 2 (load, word store), 3 (sub-word store), 1 (misaligned).
// Backpressure: one transaction in flight; the losing port holds req with ack low until it is served.
// Ports: clock, reset (async, active-high);
//        p0_*/p1_*: req/we/size/addr/wdata in, rdata/ack/err out (rdata/err held until next ack);
//        mem_*: word-aligned addr, wdata, re, we, size (always word) out; combinational rdata in.
module data_mem_access_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter bit FIXED_PRIORITY = 1'b1,
   parameter bit BIG_ENDIAN     = 1'b1
) (
   input  logic        clock,
   input  logic        reset,

   input  logic        p0_req_in,
   input  logic        p0_we_in,
   input  logic [1:0]  p0_size_in,
   input  logic [31:0] p0_addr_in,
   input  logic [31:0] p0_wdata_in,
   output logic [31:0] p0_rdata_out,
   output logic        p0_ack_out,
   output logic        p0_err_out,

   input  logic        p1_req_in,
   input  logic        p1_we_in,
   input  logic [1:0]  p1_size_in,
   input  logic [31:0] p1_addr_in,
   input  logic [31:0] p1_wdata_in,
   output logic [31:0] p1_rdata_out,
   output logic        p1_ack_out,
   output logic        p1_err_out,

   output logic [31:0] mem_addr_out,
   output logic [31:0] mem_wdata_out,
   output logic        mem_re_out,
   output logic        mem_we_out,
   output logic [1:0]  mem_size_out,
   input  logic [31:0] mem_rdata_in
);

   state_t      state_q;
   state_t      state_d;

   req_t        req_q;
   logic        gnt_q;
   logic        last_grant_q;
   logic [31:0] merged_q;

   logic        grant_vld;
   logic        grant_id;
   req_t        win_req;
   logic        win_misaligned;

   logic [31:0] lane_load;
   logic [31:0] lane_merged;

   logic        upd_vld;
   logic        upd_id;
   logic [31:0] upd_rdata;
   logic        upd_err;

   logic [31:0] p0_rdata_q;
   logic        p0_err_q;
   logic [31:0] p1_rdata_q;
   logic        p1_err_q;

   // ------------------------------------------------------------------
   // Arbitration on the raw req inputs; only consumed while in IDLE.
   // ------------------------------------------------------------------
   always_comb begin
      grant_vld = p0_req_in | p1_req_in;
      if (p0_req_in && p1_req_in) begin
         // Round-robin tie goes to whichever port was not granted last time.
         grant_id = FIXED_PRIORITY ? PORT_0 : ~last_grant_q;
      end else begin
         grant_id = p1_req_in ? PORT_1 : PORT_0;
      end

      if (grant_id == PORT_1) begin
         win_req = '{we: p1_we_in, size: p1_size_in, addr: p1_addr_in, wdata: p1_wdata_in};
      end else begin
         win_req = '{we: p0_we_in, size: p0_size_in, addr: p0_addr_in, wdata: p0_wdata_in};
      end
      win_misaligned = is_misaligned(win_req.size, win_req.addr[1:0]);
   end

   // ------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ------------------------------------------------------------------
   // FSM: next state
   // ------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (grant_vld) begin
               if (win_misaligned) begin
                  state_d = ST_ACK;
               end else if (!win_req.we) begin
                  state_d = ST_RD;
               end else if (is_subword(win_req.size)) begin
                  state_d = ST_RMW_RD;
               end else begin
                  state_d = ST_WR;
               end
            end
         end
         ST_RD:     state_d = ST_ACK;
         ST_WR:     state_d = ST_ACK;
         ST_RMW_RD: state_d = ST_RMW_WR;
         ST_RMW_WR: state_d = ST_ACK;
         ST_ACK:    state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // FSM: outputs
   // ------------------------------------------------------------------
   always_comb begin
      mem_re_out    = 1'b0;
      mem_we_out    = 1'b0;
      mem_wdata_out = '0;
      p0_ack_out    = 1'b0;
      p1_ack_out    = 1'b0;
      case (state_q)
         ST_RD:     mem_re_out = 1'b1;
         ST_RMW_RD: mem_re_out = 1'b1;
         ST_WR: begin
            mem_we_out    = 1'b1;
            mem_wdata_out = req_q.wdata;
         end
         ST_RMW_WR: begin
            mem_we_out    = 1'b1;
            mem_wdata_out = merged_q;
         end
         ST_ACK: begin
            p0_ack_out = (gnt_q == PORT_0);
            p1_ack_out = (gnt_q == PORT_1);
         end
         default: ;
      endcase
   end

   assign mem_addr_out = {req_q.addr[31:2], 2'b00};
   assign mem_size_out = SIZE_WORD;

   // ------------------------------------------------------------------
   // Lane extract / merge against the live memory read data
   // ------------------------------------------------------------------
   mem_lane_unit #(
      .BIG_ENDIAN (BIG_ENDIAN)
   ) u_lane (
      .word        (mem_rdata_in),
      .addr_lo     (req_q.addr[1:0]),
      .size        (req_q.size),
      .wdata       (req_q.wdata),
      .load_data   (lane_load),
      .merged_word (lane_merged)
   );

   // ------------------------------------------------------------------
   // Request latch, grant history and RMW merge buffer
   // ------------------------------------------------------------------
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         req_q        <= '0;
         gnt_q        <= PORT_0;
         last_grant_q <= PORT_1;
         merged_q     <= '0;
      end else begin
         if (state_q == ST_IDLE && grant_vld) begin
            req_q        <= win_req;
            gnt_q        <= grant_id;
            last_grant_q <= grant_id;
         end
         if (state_q == ST_RMW_RD) begin
            merged_q <= lane_merged;
         end
      end
   end

   // ------------------------------------------------------------------
   // Per-port result registers, loaded on the edge that enters ACK so
   // they change together with the ack pulse and hold afterwards.
   // ------------------------------------------------------------------
   always_comb begin
      upd_vld   = 1'b0;
      upd_id    = gnt_q;
      upd_rdata = '0;
      upd_err   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (grant_vld && win_misaligned) begin
               upd_vld = 1'b1;
               upd_id  = grant_id;
               upd_err = 1'b1;
            end
         end
         ST_RD: begin
            upd_vld   = 1'b1;
            upd_rdata = lane_load;
         end
         ST_WR, ST_RMW_WR: upd_vld = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         p0_rdata_q <= '0;
         p0_err_q   <= 1'b0;
         p1_rdata_q <= '0;
         p1_err_q   <= 1'b0;
      end else if (upd_vld) begin
         if (upd_id == PORT_0) begin
            p0_rdata_q <= upd_rdata;
            p0_err_q   <= upd_err;
         end else begin
            p1_rdata_q <= upd_rdata;
            p1_err_q   <= upd_err;
         end
      end
   end

   assign p0_rdata_out = p0_rdata_q;
   assign p0_err_out   = p0_err_q;
   assign p1_rdata_out = p1_rdata_q;
   assign p1_err_out   = p1_err_q;

endmodule

// File: tb/tb_data_mem_access_ctrl.sv
// Purpose: directed table-driven bench for data_mem_access_ctrl (fixed-priority and round-robin builds).
// Latency: n/a.
// Backpressure: n/a.
module tb_data_mem_access_ctrl;
   import mem_ctrl_pkg::*;

   logic        clock;
   logic        reset;
   logic        p0_req, p0_we, p1_req, p1_we;
   logic [1:0]  p0_size, p1_size;
   logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;

   logic [31:0] fp_p0_rdata, fp_p1_rdata, rr_p0_rdata, rr_p1_rdata;
   logic        fp_p0_ack, fp_p1_ack, fp_p0_err, fp_p1_err;
   logic        rr_p0_ack, rr_p1_ack, rr_p0_err, rr_p1_err;
   logic [31:0] fp_mem_addr, fp_mem_wdata, fp_mem_rdata;
   logic [31:0] rr_mem_addr, rr_mem_wdata, rr_mem_rdata;
   logic        fp_mem_re, fp_mem_we, rr_mem_re, rr_mem_we;
   logic [1:0]  fp_mem_size, rr_mem_size;

   logic [31:0] mem_fp [0:63];
   logic [31:0] mem_rr [0:63];
   logic        mem_init;

   int n_checks = 0;
   int n_fail   = 0;
   int excl_viol = 0;
   int fp_we_pulses = 0;

   data_mem_access_ctrl #(.FIXED_PRIORITY(1'b1), .BIG_ENDIAN(1'b1)) u_fp (
      .clock(clock), .reset(reset),
      .p0_req_in(p0_req), .p0_we_in(p0_we), .p0_size_in(p0_size), .p0_addr_in(p0_addr),
      .p0_wdata_in(p0_wdata), .p0_rdata_out(fp_p0_rdata), .p0_ack_out(fp_p0_ack), .p0_err_out(fp_p0_err),
      .p1_req_in(p1_req), .p1_we_in(p1_we), .p1_size_in(p1_size), .p1_addr_in(p1_addr),
      .p1_wdata_in(p1_wdata), .p1_rdata_out(fp_p1_rdata), .p1_ack_out(fp_p1_ack), .p1_err_out(fp_p1_err),
      .mem_addr_out(fp_mem_addr), .mem_wdata_out(fp_mem_wdata), .mem_re_out(fp_mem_re),
      .mem_we_out(fp_mem_we), .mem_size_out(fp_mem_size), .mem_rdata_in(fp_mem_rdata));

   data_mem_access_ctrl #(.FIXED_PRIORITY(1'b0), .BIG_ENDIAN(1'b1)) u_rr (
      .clock(clock), .reset(reset),
      .p0_req_in(p0_req), .p0_we_in(p0_we), .p0_size_in(p0_size), .p0_addr_in(p0_addr),
      .p0_wdata_in(p0_wdata), .p0_rdata_out(rr_p0_rdata), .p0_ack_out(rr_p0_ack), .p0_err_out(rr_p0_err),
      .p1_req_in(p1_req), .p1_we_in(p1_we), .p1_size_in(p1_size), .p1_addr_in(p1_addr),
      .p1_wdata_in(p1_wdata), .p1_rdata_out(rr_p1_rdata), .p1_ack_out(rr_p1_ack), .p1_err_out(rr_p1_err),
      .mem_addr_out(rr_mem_addr), .mem_wdata_out(rr_mem_wdata), .mem_re_out(rr_mem_re),
      .mem_we_out(rr_mem_we), .mem_size_out(rr_mem_size), .mem_rdata_in(rr_mem_rdata));

   // Simple word memories standing in for data_memory (combinational read, posedge write).
   assign fp_mem_rdata = mem_fp[fp_mem_addr[7:2]];
   assign rr_mem_rdata = mem_rr[rr_mem_addr[7:2]];

   always @(posedge clock) begin
      if (mem_init) begin
         for (int i = 0; i < 64; i++) begin
            mem_fp[i] <= '0;
            mem_rr[i] <= '0;
         end
      end else begin
         if (fp_mem_we) mem_fp[fp_mem_addr[7:2]] <= fp_mem_wdata;
         if (rr_mem_we) mem_rr[rr_mem_addr[7:2]] <= rr_mem_wdata;
      end
   end

   always @(negedge clock) begin
      if ((fp_mem_re && fp_mem_we) || (rr_mem_re && rr_mem_we)) excl_viol <= excl_viol + 1;
      if (fp_mem_we) fp_we_pulses <= fp_we_pulses + 1;
   end

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic        port;
      logic        we;
      logic [1:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_err;
      int          exp_lat;
      int          exp_re;
      int          exp_we;
      logic [31:0] exp_word;
   } vec_t;

   vec_t        vecs [14];
   vec_t        post_rst;
   logic [31:0] last_rdata [2];
   logic        last_err   [2];

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b, expected %b", name, act, exp);
      end
   endtask

   task automatic drive(input logic port, input logic req, input logic we, input logic [1:0] size,
                        input logic [31:0] addr, input logic [31:0] wdata);
      if (port == PORT_0) begin
         p0_req = req; p0_we = we; p0_size = size; p0_addr = addr; p0_wdata = wdata;
      end else begin
         p1_req = req; p1_we = we; p1_size = size; p1_addr = addr; p1_wdata = wdata;
      end
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      int          lat, re_cnt, we_cnt;
      logic        got_ack, other_ack, rr_ack;
      logic [31:0] we_addr, got_rdata, rr_rdata, oth_rdata;
      logic        got_err, rr_err, oth_err;
      lat = 0; re_cnt = 0; we_cnt = 0;
      got_ack = 1'b0; other_ack = 1'b0; rr_ack = 1'b0; we_addr = '0;
      @(negedge clock);
      drive(v.port, 1'b1, v.we, v.size, v.addr, v.wdata);
      while (!got_ack && lat < 10) begin
         @(negedge clock);
         lat++;
         if (fp_mem_re) re_cnt++;
         if (fp_mem_we) begin
            we_cnt++;
            we_addr = fp_mem_addr;
         end
         if (v.port == PORT_1) begin
            got_ack = fp_p1_ack; rr_ack = rr_p1_ack;
            if (fp_p0_ack) other_ack = 1'b1;
         end else begin
            got_ack = fp_p0_ack; rr_ack = rr_p0_ack;
            if (fp_p1_ack) other_ack = 1'b1;
         end
      end
      drive(v.port, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
      if (v.port == PORT_1) begin
         got_rdata = fp_p1_rdata; got_err = fp_p1_err; rr_rdata = rr_p1_rdata; rr_err = rr_p1_err;
         oth_rdata = fp_p0_rdata; oth_err = fp_p0_err;
      end else begin
         got_rdata = fp_p0_rdata; got_err = fp_p0_err; rr_rdata = rr_p0_rdata; rr_err = rr_p0_err;
         oth_rdata = fp_p1_rdata; oth_err = fp_p1_err;
      end
      chk32($sformatf("%s latency", tag), lat, v.exp_lat);
      chk32($sformatf("%s rdata", tag), got_rdata, v.exp_rdata);
      chk1($sformatf("%s err", tag), got_err, v.exp_err);
      chk32($sformatf("%s mem_re_cycles", tag), re_cnt, v.exp_re);
      chk32($sformatf("%s mem_we_cycles", tag), we_cnt, v.exp_we);
      if (we_cnt > 0) chk32($sformatf("%s mem_addr", tag), we_addr, {v.addr[31:2], 2'b00});
      chk32($sformatf("%s mem_word", tag), mem_fp[v.addr[7:2]], v.exp_word);
      chk32($sformatf("%s rr_mem_word", tag), mem_rr[v.addr[7:2]], v.exp_word);
      chk1($sformatf("%s rr_ack_same_cycle", tag), rr_ack, 1'b1);
      chk32($sformatf("%s rr_rdata", tag), rr_rdata, v.exp_rdata);
      chk1($sformatf("%s rr_err", tag), rr_err, v.exp_err);
      chk1($sformatf("%s other_port_ack", tag), other_ack, 1'b0);
      last_rdata[v.port] = v.exp_rdata;
      last_err[v.port]   = v.exp_err;
      chk32($sformatf("%s other_port_rdata", tag), oth_rdata, last_rdata[!v.port]);
      chk1($sformatf("%s other_port_err", tag), oth_err, last_err[!v.port]);
   endtask

   initial begin
      int snap, cyc, fp0, fp1_early, fp1_late;
      int rrq[$];

      //          port    we    size       addr          wdata         rdata         err  lat re we word
      vecs[0]  = '{PORT_0, 1'b1, SIZE_WORD, 32'h10000010, 32'hDEADBEEF, 32'h00000000, 1'b0, 2, 0, 1, 32'hDEADBEEF};
      vecs[1]  = '{PORT_0, 1'b0, SIZE_WORD, 32'h10000010, 32'h00000000, 32'hDEADBEEF, 1'b0, 2, 1, 0, 32'hDEADBEEF};
      vecs[2]  = '{PORT_0, 1'b1, SIZE_WORD, 32'h10000010, 32'h11223344, 32'h00000000, 1'b0, 2, 0, 1, 32'h11223344};
      vecs[3]  = '{PORT_0, 1'b1, SIZE_BYTE, 32'h10000011, 32'h123456A5, 32'h00000000, 1'b0, 3, 1, 1, 32'h11A53344};
      vecs[4]  = '{PORT_0, 1'b0, SIZE_HALF, 32'h10000012, 32'h00000000, 32'h00003344, 1'b0, 2, 1, 0, 32'h11A53344};
      vecs[5]  = '{PORT_0, 1'b0, SIZE_BYTE, 32'h10000010, 32'h00000000, 32'h00000011, 1'b0, 2, 1, 0, 32'h11A53344};
      vecs[6]  = '{PORT_0, 1'b1, SIZE_HALF, 32'h10000013, 32'h0000BEEF, 32'h00000000, 1'b1, 1, 0, 0, 32'h11A53344};
      vecs[7]  = '{PORT_1, 1'b1, SIZE_HALF, 32'h10000010, 32'h0000CAFE, 32'h00000000, 1'b0, 3, 1, 1, 32'hCAFE3344};
      vecs[8]  = '{PORT_1, 1'b0, SIZE_BYTE, 32'h10000013, 32'h00000000, 32'h00000044, 1'b0, 2, 1, 0, 32'hCAFE3344};
      vecs[9]  = '{PORT_1, 1'b0, SIZE_WORD, 32'h10000012, 32'h00000000, 32'h00000000, 1'b1, 1, 0, 0, 32'hCAFE3344};
      vecs[10] = '{PORT_1, 1'b1, SIZE_BYTE, 32'h10000017, 32'h00000077, 32'h00000000, 1'b0, 3, 1, 1, 32'h00000077};
      vecs[11] = '{PORT_0, 1'b0, SIZE_WORD, 32'h10000014, 32'h00000000, 32'h00000077, 1'b0, 2, 1, 0, 32'h00000077};
      vecs[12] = '{PORT_1, 1'b0, 2'b10,     32'h10000010, 32'h00000000, 32'hCAFE3344, 1'b0, 2, 1, 0, 32'hCAFE3344};
      vecs[13] = '{PORT_0, 1'b0, SIZE_BYTE, 32'h10000011, 32'h00000000, 32'h000000FE, 1'b0, 2, 1, 0, 32'hCAFE3344};
      post_rst = '{PORT_0, 1'b1, SIZE_BYTE, 32'h10000010, 32'h00000099, 32'h00000000, 1'b0, 3, 1, 1, 32'h99FE3344};

      for (int i = 0; i < 2; i++) begin
         last_rdata[i] = '0;
         last_err[i]   = 1'b0;
      end

      reset = 1'b1; mem_init = 1'b1;
      drive(PORT_0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
      drive(PORT_1, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
      repeat (2) @(negedge clock);

      // Reset state
      chk1("reset p0_ack", fp_p0_ack, 1'b0);
      chk1("reset p1_ack", fp_p1_ack, 1'b0);
      chk32("reset p0_rdata", fp_p0_rdata, 32'h0);
      chk1("reset p1_err", fp_p1_err, 1'b0);
      chk1("reset mem_re", fp_mem_re, 1'b0);
      chk1("reset mem_we", fp_mem_we, 1'b0);
      chk32("reset mem_addr", fp_mem_addr, 32'h0);
      chk32("reset mem_wdata", fp_mem_wdata, 32'h0);
      chk32("reset mem_size", {30'h0, fp_mem_size}, 32'h3);
      chk32("reset rr_mem_size", {30'h0, rr_mem_size}, 32'h3);

      mem_init = 1'b0;
      reset    = 1'b0;

      for (int i = 0; i < 14; i++) run_vec(vecs[i], $sformatf("v%0d", i));

      // Reset while the RMW read is on the bus: no write may follow, no ack.
      @(negedge clock);
      drive(PORT_0, 1'b1, 1'b1, SIZE_BYTE, 32'h10000010, 32'h00000099);
      @(negedge clock);
      chk1("rmw_pre_reset mem_re", fp_mem_re, 1'b1);
      snap = fp_we_pulses;
      reset = 1'b1;
      drive(PORT_0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
      #1;
      chk1("rmw_reset mem_we", fp_mem_we, 1'b0);
      chk1("rmw_reset mem_re", fp_mem_re, 1'b0);
      chk1("rmw_reset p0_ack", fp_p0_ack, 1'b0);
      chk32("rmw_reset p0_rdata", fp_p0_rdata, 32'h0);
      chk32("rmw_reset p1_rdata", fp_p1_rdata, 32'h0);
      chk32("rmw_reset mem_wdata", fp_mem_wdata, 32'h0);
      chk32("rmw_reset mem_addr", fp_mem_addr, 32'h0);
      repeat (2) @(negedge clock);
      reset = 1'b0;
      repeat (2) @(negedge clock);
      chk32("rmw_reset we_pulses", fp_we_pulses, snap);
      chk32("rmw_reset mem_word", mem_fp[4], 32'hCAFE3344);
      for (int i = 0; i < 2; i++) begin
         last_rdata[i] = '0;
         last_err[i]   = 1'b0;
      end
      run_vec(post_rst, "post_rst");

      // Arbitration: both ports requesting continuously.
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      drive(PORT_0, 1'b1, 1'b0, SIZE_WORD, 32'h10000010, 32'h0);
      drive(PORT_1, 1'b1, 1'b0, SIZE_WORD, 32'h10000014, 32'h0);
      cyc = 0; fp0 = 0; fp1_early = 0; fp1_late = 0;
      while (fp1_late < 2 && cyc < 80) begin
         @(negedge clock);
         cyc++;
         if (p0_req) begin
            if (rr_p0_ack) rrq.push_back(0);
            if (rr_p1_ack) rrq.push_back(1);
            if (fp_p1_ack) fp1_early++;
            if (fp_p0_ack) begin
               fp0++;
               if (fp0 == 4) p0_req = 1'b0;
            end
         end else if (fp_p1_ack) begin
            fp1_late++;
         end
      end
      p1_req = 1'b0;
      chk32("arb fp p0_acks", fp0, 4);
      chk32("arb fp p1_acks_while_p0", fp1_early, 0);
      chk32("arb fp p1_acks_after_p0", fp1_late, 2);
      chk32("arb rr ack_count", rrq.size(), 4);
      for (int i = 0; i < 4; i++) begin
         if (i < rrq.size()) chk32($sformatf("arb rr order[%0d]", i), rrq[i], i % 2);
      end

      repeat (4) @(negedge clock);
      chk32("re_we_exclusive", excl_viol, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
